// File: rtl/riscv_defs.sv
// Shared RISC-V pipeline constants and the operand-forwarding select encoding
// used by decode-stage hazard logic.
package riscv_defs;

  localparam int NB_OPERAND = 5;
  localparam int NUM_REGS   = 1 << NB_OPERAND;

  // Wide enough for register file, up to six writing stages and the multi-cycle bus.
  localparam int NB_FWD_SEL = 3;

  typedef enum logic [NB_FWD_SEL-1:0] {
    FWD_RF  = 3'd0,
    FWD_EX  = 3'd1,
    FWD_MEM = 3'd2,
    FWD_WB  = 3'd3,
    FWD_MC  = 3'd4
  } fwd_sel_e;

  function automatic logic [NB_FWD_SEL-1:0] fwd_stage_sel(input int stage);
    return NB_FWD_SEL'(stage + 1);
  endfunction

  function automatic logic [NB_FWD_SEL-1:0] fwd_mc_sel(input int num_stages);
    return NB_FWD_SEL'(num_stages + 1);
  endfunction

endpackage

// File: rtl/forwarding_scoreboard_if.sv
// Bundle between decode/issue and the forwarding scoreboard: operand reads,
// pipeline stage writes, issue/completion of multi-cycle ops, and results.
interface forwarding_scoreboard_if #(
  parameter int NUM_RS          = 2,
  parameter int NUM_FWD_STAGES  = 3,
  parameter int MAX_MC_INFLIGHT = 4
);
  import riscv_defs::*;

  localparam int NB_MC_CNT = $clog2(MAX_MC_INFLIGHT + 1);

  logic [NUM_RS-1:0][NB_OPERAND-1:0]         i_rs;
  logic [NUM_RS-1:0]                         i_rs_used;
  logic [NUM_FWD_STAGES-1:0]                 i_stage_rf_write;
  logic [NUM_FWD_STAGES-1:0][NB_OPERAND-1:0] i_stage_rd;
  logic [NUM_FWD_STAGES-1:0]                 i_stage_data_valid;
  logic                                      i_issue_valid;
  logic [NB_OPERAND-1:0]                     i_issue_rd;
  logic                                      i_issue_mc;
  logic                                      i_flush;
  logic                                      i_mc_done;
  logic [NB_OPERAND-1:0]                     i_mc_rd;
  logic [NUM_RS-1:0][NB_FWD_SEL-1:0]         o_fwd_sel;
  logic                                      o_stall;
  logic [NB_MC_CNT-1:0]                      o_mc_count;
  logic [31:0]                               o_stall_cycles;

  modport master (
    output i_rs, i_rs_used, i_stage_rf_write, i_stage_rd, i_stage_data_valid,
           i_issue_valid, i_issue_rd, i_issue_mc, i_flush, i_mc_done, i_mc_rd,
    input  o_fwd_sel, o_stall, o_mc_count, o_stall_cycles
  );

  modport slave (
    input  i_rs, i_rs_used, i_stage_rf_write, i_stage_rd, i_stage_data_valid,
           i_issue_valid, i_issue_rd, i_issue_mc, i_flush, i_mc_done, i_mc_rd,
    output o_fwd_sel, o_stall, o_mc_count, o_stall_cycles
  );

endinterface

// File: rtl/fwd_port_select.sv
// Forwarding source and hazard stall for a single decode read port.
module fwd_port_select
  import riscv_defs::*;
#(
  parameter int NUM_FWD_STAGES = 3
) (
  input  logic [NB_OPERAND-1:0]                     rs,
  input  logic                                      rs_used,
  input  logic [NUM_FWD_STAGES-1:0]                 stage_rf_write,
  input  logic [NUM_FWD_STAGES-1:0][NB_OPERAND-1:0] stage_rd,
  input  logic [NUM_FWD_STAGES-1:0]                 stage_data_valid,
  input  logic                                      mc_done,
  input  logic [NB_OPERAND-1:0]                     mc_rd,
  input  logic [NUM_REGS-1:0]                       pending,
  output logic [NB_FWD_SEL-1:0]                     fwd_sel,
  output logic                                      port_stall
);

  logic active;
  logic mc_hit;
  logic stage_hit;
  logic stage_ready;

  // x0 is never active, so a stage writing x0 can never be selected.
  always_comb begin
    active      = rs_used && (rs != '0);
    mc_hit      = mc_done && (mc_rd == rs);
    stage_hit   = 1'b0;
    stage_ready = 1'b1;
    fwd_sel     = FWD_RF;
    if (active) begin
      if (mc_hit) begin
        fwd_sel = fwd_mc_sel(NUM_FWD_STAGES);
      end else begin
        for (int s = 0; s < NUM_FWD_STAGES; s++) begin
          if (!stage_hit && stage_rf_write[s] && (stage_rd[s] == rs)) begin
            stage_hit   = 1'b1;
            stage_ready = stage_data_valid[s];
            fwd_sel     = fwd_stage_sel(s);
          end
        end
      end
    end
    port_stall = active && ((pending[rs] && !mc_hit) || !stage_ready);
  end

endmodule

// File: rtl/forwarding_scoreboard.sv
// Decode-stage operand forwarding and hazard stall, with a pending-write
// scoreboard tracking outstanding multi-cycle (mul/div) results.
module forwarding_scoreboard
  import riscv_defs::*;
#(
  parameter int NUM_RS          = 2,
  parameter int NUM_FWD_STAGES  = 3,
  parameter int MAX_MC_INFLIGHT = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  forwarding_scoreboard_if.slave bus
);

  localparam int NB_MC_CNT = $clog2(MAX_MC_INFLIGHT + 1);

  logic [NUM_REGS-1:1]               pending_q;
  logic [NUM_REGS-1:1]               pending_nxt;
  logic [NUM_REGS-1:0]               pending;
  logic [NB_MC_CNT-1:0]              mc_count_q;
  logic [31:0]                       stall_cycles_q;
  logic [NUM_RS-1:0][NB_FWD_SEL-1:0] fwd_sel;
  logic [NUM_RS-1:0]                 port_stall;
  logic                              mc_clear;
  logic                              mc_set;
  logic                              waw_stall;
  logic                              mc_full_stall;
  logic                              stall;

  assign pending = {pending_q, 1'b0};

  for (genvar g = 0; g < NUM_RS; g++) begin : g_port
    fwd_port_select #(
      .NUM_FWD_STAGES(NUM_FWD_STAGES)
    ) u_port_select (
      .rs               (bus.i_rs[g]),
      .rs_used          (bus.i_rs_used[g]),
      .stage_rf_write   (bus.i_stage_rf_write),
      .stage_rd         (bus.i_stage_rd),
      .stage_data_valid (bus.i_stage_data_valid),
      .mc_done          (bus.i_mc_done),
      .mc_rd            (bus.i_mc_rd),
      .pending          (pending),
      .fwd_sel          (fwd_sel[g]),
      .port_stall       (port_stall[g])
    );
  end

  // A completion only retires a write that is actually outstanding, which keeps
  // the counter equal to the number of pending bits and so it can never wrap.
  assign mc_clear      = bus.i_mc_done && pending[bus.i_mc_rd];
  assign waw_stall     = bus.i_issue_valid && pending[bus.i_issue_rd] &&
                         !(bus.i_mc_done && (bus.i_mc_rd == bus.i_issue_rd));
  assign mc_full_stall = bus.i_issue_valid && bus.i_issue_mc && !mc_clear &&
                         (mc_count_q == NB_MC_CNT'(MAX_MC_INFLIGHT));
  assign stall         = !bus.i_flush && (|port_stall || waw_stall || mc_full_stall);
  assign mc_set        = bus.i_issue_valid && bus.i_issue_mc && !bus.i_flush &&
                         !stall && (bus.i_issue_rd != '0);

  // Set is applied after clear so a same-register retire and re-issue stays pending.
  always_comb begin
    pending_nxt = pending_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (mc_clear && (bus.i_mc_rd == NB_OPERAND'(r))) pending_nxt[r] = 1'b0;
      if (mc_set && (bus.i_issue_rd == NB_OPERAND'(r))) pending_nxt[r] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_q      <= '0;
      mc_count_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      pending_q <= pending_nxt;
      if (mc_set && !mc_clear) begin
        mc_count_q <= mc_count_q + NB_MC_CNT'(1);
      end else if (mc_clear && !mc_set) begin
        mc_count_q <= mc_count_q - NB_MC_CNT'(1);
      end
      if (stall && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
    end
  end

  assign bus.o_fwd_sel      = fwd_sel;
  assign bus.o_stall        = stall;
  assign bus.o_mc_count     = mc_count_q;
  assign bus.o_stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed and randomized checks of forwarding_scoreboard against a
// register-level reference model of forwarding, stalls and pending writes.
module tb_forwarding_scoreboard;

  localparam int NRS   = 2;
  localparam int NFS   = 3;
  localparam int MAXMC = 4;

  logic clk;
  logic rst_n;

  int tests_run;
  int tests_failed;

  int rs_v    [NRS];
  bit used_v  [NRS];
  bit wr_v    [NFS];
  int srd_v   [NFS];
  bit dv_v    [NFS];
  bit iv_v;
  bit imc_v;
  int ird_v;
  bit flush_v;
  bit done_v;
  int mcrd_v;

  bit     pend_m [32];
  int     count_m;
  longint stalls_m;

  forwarding_scoreboard_if #(
    .NUM_RS(NRS), .NUM_FWD_STAGES(NFS), .MAX_MC_INFLIGHT(MAXMC)
  ) bus ();

  forwarding_scoreboard #(
    .NUM_RS(NRS), .NUM_FWD_STAGES(NFS), .MAX_MC_INFLIGHT(MAXMC)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    for (int p = 0; p < NRS; p++) begin
      rs_v[p]   = 0;
      used_v[p] = 1'b0;
    end
    for (int s = 0; s < NFS; s++) begin
      wr_v[s]  = 1'b0;
      srd_v[s] = 0;
      dv_v[s]  = 1'b1;
    end
    iv_v = 1'b0; imc_v = 1'b0; ird_v = 0;
    flush_v = 1'b0; done_v = 1'b0; mcrd_v = 0;
  endtask

  task automatic applyStimulus();
    for (int p = 0; p < NRS; p++) begin
      bus.i_rs[p]      = 5'(rs_v[p]);
      bus.i_rs_used[p] = used_v[p];
    end
    for (int s = 0; s < NFS; s++) begin
      bus.i_stage_rf_write[s]   = wr_v[s];
      bus.i_stage_rd[s]         = 5'(srd_v[s]);
      bus.i_stage_data_valid[s] = dv_v[s];
    end
    bus.i_issue_valid = iv_v;
    bus.i_issue_mc    = imc_v;
    bus.i_issue_rd    = 5'(ird_v);
    bus.i_flush       = flush_v;
    bus.i_mc_done     = done_v;
    bus.i_mc_rd       = 5'(mcrd_v);
  endtask

  // Reference model: which source supplies each operand, and whether decode must wait.
  function automatic int exp_sel(int p);
    int sel = 0;
    bit found = 1'b0;
    if (used_v[p] && rs_v[p] != 0) begin
      if (done_v && mcrd_v == rs_v[p]) begin
        sel = NFS + 1;
      end else begin
        for (int s = 0; s < NFS; s++) begin
          if (!found && wr_v[s] && srd_v[s] != 0 && srd_v[s] == rs_v[p]) begin
            found = 1'b1;
            sel   = s + 1;
          end
        end
      end
    end
    return sel;
  endfunction

  function automatic bit exp_stall();
    bit st = 1'b0;
    int sel;
    if (flush_v) return 1'b0;
    for (int p = 0; p < NRS; p++) begin
      if (used_v[p] && rs_v[p] != 0) begin
        if (pend_m[rs_v[p]] && !(done_v && mcrd_v == rs_v[p])) st = 1'b1;
        sel = exp_sel(p);
        if (sel >= 1 && sel <= NFS && !dv_v[sel-1]) st = 1'b1;
      end
    end
    if (iv_v && pend_m[ird_v] && !(done_v && mcrd_v == ird_v)) st = 1'b1;
    if (iv_v && imc_v && count_m == MAXMC && !(done_v && pend_m[mcrd_v])) st = 1'b1;
    return st;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) pend_m[r] = 1'b0;
    count_m  = 0;
    stalls_m = 0;
  endtask

  task automatic model_step();
    bit st;
    bit clr;
    bit set;
    if (!rst_n) return;
    st  = exp_stall();
    clr = done_v && mcrd_v != 0 && pend_m[mcrd_v];
    set = iv_v && imc_v && !flush_v && !st && ird_v != 0;
    if (st && stalls_m != 64'hFFFF_FFFF) stalls_m++;
    if (clr) begin
      pend_m[mcrd_v] = 1'b0;
      count_m--;
    end
    if (set) begin
      pend_m[ird_v] = 1'b1;
      count_m++;
    end
  endtask

  task automatic settle();
    applyStimulus();
    #1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkCycle(input string tag);
    for (int p = 0; p < NRS; p++) begin
      checkOutput($sformatf("%s_sel%0d", tag, p), 32'(bus.o_fwd_sel[p]), exp_sel(p));
    end
    checkOutput({tag, "_stall"}, 32'(bus.o_stall), 32'(exp_stall()));
    checkOutput({tag, "_mc_count"}, 32'(bus.o_mc_count), count_m);
    checkOutput({tag, "_stall_cycles"}, bus.o_stall_cycles, stalls_m[31:0]);
  endtask

  task automatic randomInputs();
    for (int p = 0; p < NRS; p++) begin
      rs_v[p]   = $urandom_range(0, 7);
      used_v[p] = ($urandom_range(0, 3) != 0);
    end
    for (int s = 0; s < NFS; s++) begin
      wr_v[s]  = ($urandom_range(0, 1) == 1);
      srd_v[s] = $urandom_range(0, 7);
      dv_v[s]  = ($urandom_range(0, 3) != 0);
    end
    iv_v    = ($urandom_range(0, 1) == 1);
    imc_v   = ($urandom_range(0, 1) == 1);
    ird_v   = $urandom_range(0, 7);
    flush_v = ($urandom_range(0, 7) == 0);
    done_v  = ($urandom_range(0, 2) == 0);
    mcrd_v  = $urandom_range(0, 7);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    clearInputs();
    model_reset();
    settle();
    checkCycle("reset");
    checkOutput("reset_mc_count", 32'(bus.o_mc_count), 0);
    checkOutput("reset_stall_cycles", bus.o_stall_cycles, 0);
    tick();
    rst_n = 1'b1;
    #1;

    // Youngest matching stage wins over an older one.
    clearInputs();
    wr_v[0] = 1'b1; srd_v[0] = 5;
    wr_v[2] = 1'b1; srd_v[2] = 5;
    rs_v[0] = 5; used_v[0] = 1'b1;
    settle();
    checkCycle("fwd_ex");
    checkOutput("fwd_ex_sel0", 32'(bus.o_fwd_sel[0]), 1);
    checkOutput("fwd_ex_stall", 32'(bus.o_stall), 0);
    tick();

    // Load-use: EX result not yet available.
    clearInputs();
    wr_v[0] = 1'b1; srd_v[0] = 7; dv_v[0] = 1'b0;
    rs_v[1] = 7; used_v[1] = 1'b1;
    settle();
    checkCycle("load_use");
    checkOutput("load_use_stall", 32'(bus.o_stall), 1);
    tick();
    clearInputs();
    settle();
    checkOutput("load_use_stall_cycles", bus.o_stall_cycles, 1);

    // Divide to x9, dependent read waits for completion.
    clearInputs();
    iv_v = 1'b1; imc_v = 1'b1; ird_v = 9;
    settle();
    checkCycle("div_issue");
    tick();
    for (int c = 0; c < 2; c++) begin
      clearInputs();
      rs_v[0] = 9; used_v[0] = 1'b1;
      settle();
      checkCycle($sformatf("div_wait%0d", c));
      checkOutput($sformatf("div_wait%0d_stall", c), 32'(bus.o_stall), 1);
      tick();
    end
    done_v = 1'b1; mcrd_v = 9;
    settle();
    checkCycle("div_done");
    checkOutput("div_done_sel0", 32'(bus.o_fwd_sel[0]), 4);
    checkOutput("div_done_stall", 32'(bus.o_stall), 0);
    tick();

    // Fill the multi-cycle tracker, then try one more with and without a retire.
    for (int r = 1; r <= 4; r++) begin
      clearInputs();
      iv_v = 1'b1; imc_v = 1'b1; ird_v = r;
      settle();
      checkCycle($sformatf("mc_fill%0d", r));
      tick();
    end
    clearInputs();
    iv_v = 1'b1; imc_v = 1'b1; ird_v = 6;
    settle();
    checkCycle("mc_full");
    checkOutput("mc_full_stall", 32'(bus.o_stall), 1);
    checkOutput("mc_full_count", 32'(bus.o_mc_count), 4);
    tick();
    done_v = 1'b1; mcrd_v = 1;
    settle();
    checkCycle("mc_swap");
    checkOutput("mc_swap_stall", 32'(bus.o_stall), 0);
    tick();
    clearInputs();
    settle();
    checkOutput("mc_swap_count", 32'(bus.o_mc_count), 4);

    // Flush suppresses stall and the scoreboard set.
    clearInputs();
    iv_v = 1'b1; imc_v = 1'b1; ird_v = 7; flush_v = 1'b1;
    rs_v[0] = 2; used_v[0] = 1'b1;
    settle();
    checkCycle("flush");
    checkOutput("flush_stall", 32'(bus.o_stall), 0);
    tick();
    clearInputs();
    rs_v[0] = 7; used_v[0] = 1'b1;
    settle();
    checkCycle("flush_after");
    checkOutput("flush_after_stall", 32'(bus.o_stall), 0);
    tick();

    // x0 never forwards or stalls.
    clearInputs();
    for (int s = 0; s < NFS; s++) begin
      wr_v[s] = 1'b1; srd_v[s] = 0; dv_v[s] = 1'b0;
    end
    used_v[0] = 1'b1; used_v[1] = 1'b1;
    settle();
    checkCycle("x0");
    checkOutput("x0_sel0", 32'(bus.o_fwd_sel[0]), 0);
    checkOutput("x0_stall", 32'(bus.o_stall), 0);
    tick();

    // Asynchronous reset in mid-cycle with several ops outstanding.
    clearInputs();
    rs_v[0] = 6; used_v[0] = 1'b1;
    settle();
    checkOutput("async_pre_stall", 32'(bus.o_stall), 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checkCycle("async_rst");
    checkOutput("async_rst_count", 32'(bus.o_mc_count), 0);
    checkOutput("async_rst_stall", 32'(bus.o_stall), 0);
    tick();
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 400; i++) begin
      randomInputs();
      settle();
      checkCycle($sformatf("rnd%0d", i));
      checkOutput($sformatf("rnd%0d_count_bound", i),
                  32'(bus.o_mc_count <= 3'(MAXMC)), 1);
      if (i == 200) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checkCycle("rnd_rst");
        tick();
        rst_n = 1'b1;
        #1;
      end else begin
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
